// File: rtl/joybus_pkg.sv
// joybus_pkg: shared types and constants for the joybus port scheduler and
// its round-robin arbiter (FSM state encoding, completion status codes,
// joybus command bytes).
package joybus_pkg;

  localparam int MAX_PORTS = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RESP_OK       = 2'd0,
    RESP_NO_REPLY = 2'd1,
    RESP_TIMEOUT  = 2'd2,
    RESP_POLL_OK  = 2'd3
  } resp_status_t;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

endpackage

// File: rtl/joybus_rr_arbiter.sv
// joybus_rr_arbiter: combinational round-robin pick. Returns the first set
// bit of req at or after ptr, wrapping modulo NUM_PORTS.
//   req  in  4  candidate bits (bits >= NUM_PORTS must be 0)
//   ptr  in  2  search start, must be < NUM_PORTS
//   pick out 2  chosen index (0 when none)
//   any  out 1  at least one candidate set
module joybus_rr_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] pick,
  output logic       any
);

  logic [1:0] idx [NUM_PORTS];

  // Visit order ptr, ptr+1, ... wrapped; ptr < NUM_PORTS so one subtract suffices.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_idx
    logic [2:0] sum;
    assign sum    = {1'b0, ptr} + 3'(i);
    assign idx[i] = (sum >= 3'(NUM_PORTS)) ? 2'(sum - 3'(NUM_PORTS)) : sum[1:0];
  end

  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!any && req[idx[i]]) begin
        any  = 1'b1;
        pick = idx[i];
      end
    end
  end

endmodule

// File: rtl/joybus_port_scheduler.sv
// joybus_port_scheduler: arbitrates NUM_PORTS joybus ports onto one shared
// transceiver engine, round-robin, with inter-frame gap and reply timeout.
// Optional autopoll (define JOYBUS_AUTOPOLL_EN) issues periodic status polls.
//   clock, reset (sync, active high)
//   req_valid/req_cmd  in   per-port command requests; req_ready grant pulse
//   eng_start/eng_port/eng_cmd/eng_abort  out  engine control
//   eng_done/eng_rx_ok  in  engine completion
//   resp_valid/resp_port/resp_status  out  one completion per transaction
//   port_present  out  last known presence per port
// All pulse outputs are registered: eng_start/req_ready appear the cycle
// after ISSUE, resp_valid the cycle after eng_done or expiry.
module joybus_port_scheduler
  import joybus_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int GAP_CYC     = 100,
  parameter int TIMEOUT_CYC = 5000,
  parameter int POLL_PERIOD = 833333
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   req_valid,
  input  logic [8*NUM_PORTS-1:0] req_cmd,
  output logic [NUM_PORTS-1:0]   req_ready,
  output logic                   eng_start,
  output logic [1:0]             eng_port,
  output logic [7:0]             eng_cmd,
  input  logic                   eng_done,
  input  logic                   eng_rx_ok,
  output logic                   eng_abort,
  output logic                   resp_valid,
  output logic [1:0]             resp_port,
  output logic [1:0]             resp_status,
  output logic [NUM_PORTS-1:0]   port_present
);

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS || POLL_PERIOD < 2) begin : g_cfg_err
    $error("joybus_port_scheduler: unsupported parameter set");
  end

  state_t state, state_nxt;
  logic [3:0]  req_pad, poll_pad, cand, rdy, pres;
  logic [31:0] cmd_pad, cnt;
  logic [1:0]  rr_ptr, rr_next, pick;
  logic        any, is_poll;
  logic [NUM_PORTS-1:0] poll_pending;

  assign req_pad  = 4'(req_valid);
  assign poll_pad = 4'(poll_pending);
  assign cmd_pad  = 32'(req_cmd);
  assign cand     = req_pad | poll_pad;
  assign rr_next  = (eng_port == 2'(NUM_PORTS - 1)) ? 2'd0 : eng_port + 2'd1;

  assign req_ready    = rdy[NUM_PORTS-1:0];
  assign port_present = pres[NUM_PORTS-1:0];

  joybus_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req  (cand),
    .ptr  (rr_ptr),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = ARB;
      ARB:     state_nxt = any ? ISSUE : IDLE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (eng_done || cnt == '0) state_nxt = GAP;
      GAP:     if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One counter serves both the reply timeout (WAIT) and the gap (GAP).
  always_ff @(posedge clock) begin
    if (reset) begin
      eng_start   <= 1'b0;
      eng_abort   <= 1'b0;
      resp_valid  <= 1'b0;
      rdy         <= '0;
      eng_port    <= '0;
      eng_cmd     <= '0;
      resp_port   <= '0;
      resp_status <= '0;
      pres        <= '0;
      rr_ptr      <= '0;
      is_poll     <= 1'b0;
      cnt         <= '0;
    end else begin
      eng_start  <= 1'b0;
      eng_abort  <= 1'b0;
      resp_valid <= 1'b0;
      rdy        <= '0;
      case (state)
        ARB: if (any) begin
          // Host request beats a pending poll on the same port.
          eng_port <= pick;
          is_poll  <= !req_pad[pick];
          eng_cmd  <= req_pad[pick] ? cmd_pad[{pick, 3'b000} +: 8] : CMD_STATUS;
        end
        ISSUE: begin
          eng_start     <= 1'b1;
          rdy[eng_port] <= !is_poll;
          cnt           <= 32'(TIMEOUT_CYC - 1);
        end
        WAIT: begin
          cnt <= cnt - 32'd1;
          if (eng_done || cnt == '0) begin
            resp_valid <= 1'b1;
            resp_port  <= eng_port;
            rr_ptr     <= rr_next;
            cnt        <= 32'(GAP_CYC - 1);
            if (eng_done) begin
              // eng_done wins a same-cycle race with expiry.
              pres[eng_port] <= eng_rx_ok;
              resp_status    <= !eng_rx_ok ? RESP_NO_REPLY :
                                is_poll    ? RESP_POLL_OK  : RESP_OK;
            end else begin
              eng_abort      <= 1'b1;
              pres[eng_port] <= 1'b0;
              resp_status    <= RESP_TIMEOUT;
            end
          end
        end
        GAP:     cnt <= cnt - 32'd1;
        default: ;
      endcase
    end
  end

`ifdef JOYBUS_AUTOPOLL_EN
  logic [31:0]          poll_tmr;
  logic                 poll_wrap;
  logic [NUM_PORTS-1:0] poll_clr;

  assign poll_wrap = (poll_tmr == 32'(POLL_PERIOD - 1));

  always_comb begin
    poll_clr = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      poll_clr[i] = (state == ISSUE) && is_poll && (eng_port == 2'(i));
  end

  // A wrap re-arms every port; an already pending poll simply stays pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      poll_tmr     <= '0;
      poll_pending <= '0;
    end else begin
      poll_tmr     <= poll_wrap ? '0 : poll_tmr + 32'd1;
      poll_pending <= (poll_pending & ~poll_clr) | {NUM_PORTS{poll_wrap}};
    end
  end
`else
  assign poll_pending = '0;
`endif

endmodule
